// File: rtl/mem_master_pkg.sv
// Shared types for the CPU memory-bus initiator.
// Widths, FSM states, client ids and the range check.
package mem_master_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        CL_IF = 1'b0,
        CL_D  = 1'b1
    } client_t;

    // Full-width unsigned compare: no truncation of the address.
    function automatic logic in_range(addr_t a, int unsigned depth);
        return 32'(a) < depth;
    endfunction

endpackage

// File: rtl/mem_master_if.sv
// CPU-client handshakes and word-memory strobes in one bundle.
// master = the initiator, slave = the CPU clients plus memory.
interface mem_master_if;
    import mem_master_pkg::*;

    logic    if_req;
    addr_t   if_addr;
    logic    if_ready;
    data_t   if_rdata;
    logic    d_req;
    logic    d_we;
    addr_t   d_addr;
    data_t   d_wdata;
    logic    d_ready;
    data_t   d_rdata;
    logic    err;
    logic    busy;
    logic    mem_read;
    logic    mem_write;
    addr_t   mem_addr;
    data_t   mem_wdata;
    data_t   mem_rdata;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ready, if_rdata, d_ready, d_rdata, err, busy,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata, err, busy,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_master_rr_arb2.sv
// Two-input round-robin arbiter with one-hot grant.
// Bit 1 (data client) is favoured out of reset.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            (req == 2'b11): gnt = ptr ? 2'b10 : 2'b01;
            (req == 2'b01): gnt = 2'b01;
            (req == 2'b10): gnt = 2'b10;
            default:        gnt = 2'b00;
        endcase
    end

    // After a grant the pointer favours the client that lost.
    always_ff @(posedge clk) begin
        if (reset)
            ptr <= 1'b1;
        else if (accept && (gnt != 2'b00))
            ptr <= gnt[0];
    end

endmodule

// File: rtl/mem_master.sv
// Memory-bus initiator: arbitrates fetch and data clients onto
// the word memory, one transaction at a time.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int unsigned MEM_DEPTH    = 16,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    mem_master_if.master bus
);

    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

    state_t            state;
    client_t           cl;
    logic              we;
    logic [LAT_W-1:0]  lat;
    logic [1:0]        gnt;
    logic              accept;
    client_t           sel_cl;
    addr_t             sel_addr;
    logic              sel_we;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({bus.d_req, bus.if_req}),
        .accept (accept),
        .gnt    (gnt)
    );

    always_comb begin
        sel_cl   = gnt[1] ? CL_D : CL_IF;
        sel_addr = gnt[1] ? bus.d_addr : bus.if_addr;
        sel_we   = gnt[1] & bus.d_we;
        accept   = (state == ST_IDLE) && (gnt != 2'b00);
    end

    assign bus.busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cl            <= CL_D;
            we            <= 1'b0;
            lat           <= '0;
            bus.if_ready  <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_ready   <= 1'b0;
            bus.d_rdata   <= '0;
            bus.err       <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            unique case (state)
                ST_IDLE: if (accept) begin
                    cl  <= sel_cl;
                    we  <= sel_we;
                    lat <= '0;
                    if (!in_range(sel_addr, MEM_DEPTH)) begin
                        state        <= ST_RESP;
                        bus.err      <= 1'b1;
                        bus.if_ready <= (sel_cl == CL_IF);
                        bus.d_ready  <= (sel_cl == CL_D);
                    end else begin
                        state        <= ST_ACCESS;
                        bus.mem_addr <= sel_addr;
                        if (sel_we) begin
                            bus.mem_write <= 1'b1;
                            bus.mem_wdata <= bus.d_wdata;
                        end else begin
                            bus.mem_read  <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (we) begin
                        bus.mem_write <= 1'b0;
                        state         <= ST_RESP;
                        bus.if_ready  <= (cl == CL_IF);
                        bus.d_ready   <= (cl == CL_D);
                    end else if (lat == LAT_LAST) begin
                        bus.mem_read  <= 1'b0;
                        state         <= ST_RESP;
                        bus.if_ready  <= (cl == CL_IF);
                        bus.d_ready   <= (cl == CL_D);
                        if (cl == CL_D)
                            bus.d_rdata  <= bus.mem_rdata;
                        else
                            bus.if_rdata <= bus.mem_rdata;
                    end else begin
                        lat <= lat + 1'b1;
                    end
                end
                ST_RESP: begin
                    state        <= ST_IDLE;
                    bus.if_ready <= 1'b0;
                    bus.d_ready  <= 1'b0;
                    bus.if_rdata <= '0;
                    bus.d_rdata  <= '0;
                    bus.err      <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
